// File: rtl/butterfly_xbar_out_pipe.sv
// Registered butterfly output crossbar: permutes NUM_BF top/bottom results into two
// write-back rows by FFT stride, presented as one dual-row beat or two serial beats.
module butterfly_xbar_out_pipe #(
    parameter int unsigned NUM_BF   = 4,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned STRIDE_W = 10
) (
    input  logic                     i_CLK,
    input  logic                     i_RST_N,
    input  logic [STRIDE_W-1:0]      i_STRIDE,
    input  logic                     i_DUAL_ROW,
    input  logic [NUM_BF*DATA_W-1:0] i_BF_TOP,
    input  logic [NUM_BF*DATA_W-1:0] i_BF_BOTTOM,
    input  logic                     i_VALID,
    output logic                     o_READY,
    output logic [NUM_BF*DATA_W-1:0] o_DATA0,
    output logic [NUM_BF*DATA_W-1:0] o_DATA1,
    output logic                     o_ROW_IDX,
    output logic                     o_LAST,
    output logic                     o_VALID,
    input  logic                     i_READY
);

    localparam int LOG_NBF = $clog2(NUM_BF);
    localparam int ROW_W   = NUM_BF * DATA_W;

    typedef enum logic [1:0] {StEmpty, StBeat0, StBeat1} state_e;

    state_e            state_q, state_d;
    logic [ROW_W-1:0]  row0_q, row1_q, row0_d, row1_d;
    logic              dual_q;
    logic              in_xfer;
    int                s_log;
    logic [DATA_W-1:0] perm [2*NUM_BF];

    // log2 of the effective stride: smallest power of two >= i_STRIDE, clamped to [1, NUM_BF]
    always_comb begin
        s_log = 0;
        for (int i = 1; i <= LOG_NBF; i++) begin
            if (i_STRIDE > (STRIDE_W'(1) << (i - 1))) begin
                s_log = i;
            end
        end
    end

    // Q[k]: group g = k / 2S, offset r = k mod 2S; first half of a group from TOP, second from BOTTOM
    always_comb begin
        for (int k = 0; k < 2 * NUM_BF; k++) begin
            int g;
            int r;
            int idx;
            g   = k >> (s_log + 1);
            r   = k & ((2 << s_log) - 1);
            idx = (g << s_log) + (r & ((1 << s_log) - 1));
            if (r < (1 << s_log)) begin
                perm[k] = i_BF_TOP[idx*DATA_W +: DATA_W];
            end else begin
                perm[k] = i_BF_BOTTOM[idx*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        row0_d = '0;
        row1_d = '0;
        for (int w = 0; w < NUM_BF; w++) begin
            row0_d[w*DATA_W +: DATA_W] = perm[w];
            row1_d[w*DATA_W +: DATA_W] = perm[NUM_BF + w];
        end
    end

    always_comb begin
        o_VALID   = (state_q != StEmpty);
        o_LAST    = ((state_q == StBeat0) && dual_q) || (state_q == StBeat1);
        o_ROW_IDX = (state_q == StBeat1);
        o_DATA0   = '0;
        o_DATA1   = '0;
        unique case (state_q)
            StBeat0: begin
                o_DATA0 = row0_q;
                if (dual_q) begin
                    o_DATA1 = row1_q;
                end
            end
            StBeat1: o_DATA0 = row1_q;
            default: ;
        endcase
        // i_READY -> o_READY path lets a new transaction land as the last beat drains
        o_READY = (state_q == StEmpty) || (o_VALID && o_LAST && i_READY);
        in_xfer = i_VALID && o_READY;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StEmpty: begin
                if (in_xfer) state_d = StBeat0;
            end
            StBeat0: begin
                if (i_READY) begin
                    if (!dual_q)      state_d = StBeat1;
                    else if (in_xfer) state_d = StBeat0;
                    else              state_d = StEmpty;
                end
            end
            StBeat1: begin
                if (i_READY) state_d = in_xfer ? StBeat0 : StEmpty;
            end
            default: state_d = StEmpty;
        endcase
    end

    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            state_q <= StEmpty;
            row0_q  <= '0;
            row1_q  <= '0;
            dual_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (in_xfer) begin
                row0_q <= row0_d;
                row1_q <= row1_d;
                dual_q <= i_DUAL_ROW;
            end
        end
    end

endmodule

// File: tb/tb_butterfly_xbar_out_pipe.sv
// Self-checking bench for butterfly_xbar_out_pipe: directed plan steps plus random traffic
// against a beat-queue reference model.
module tb_butterfly_xbar_out_pipe;

    localparam int NB = 4;
    localparam int DW = 32;
    localparam int SW = 10;
    localparam int RW = NB * DW;

    typedef struct packed {
        logic [RW-1:0] d0;
        logic [RW-1:0] d1;
        logic          idx;
        logic          last;
    } beat_t;

    logic          clk;
    logic          rst_n;
    logic [SW-1:0] stride;
    logic          dual_row;
    logic [RW-1:0] bf_top;
    logic [RW-1:0] bf_bottom;
    logic          in_valid;
    logic          in_ready;
    logic [RW-1:0] data0;
    logic [RW-1:0] data1;
    logic          row_idx;
    logic          last;
    logic          out_valid;
    logic          out_ready;

    logic [DW-1:0] top_w [NB];
    logic [DW-1:0] bot_w [NB];
    beat_t         exp_q [$];
    int            total;
    int            bad;

    butterfly_xbar_out_pipe #(
        .NUM_BF  (NB),
        .DATA_W  (DW),
        .STRIDE_W(SW)
    ) dut (
        .i_CLK      (clk),
        .i_RST_N    (rst_n),
        .i_STRIDE   (stride),
        .i_DUAL_ROW (dual_row),
        .i_BF_TOP   (bf_top),
        .i_BF_BOTTOM(bf_bottom),
        .i_VALID    (in_valid),
        .o_READY    (in_ready),
        .o_DATA0    (data0),
        .o_DATA1    (data1),
        .o_ROW_IDX  (row_idx),
        .o_LAST     (last),
        .o_VALID    (out_valid),
        .i_READY    (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chkw(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic void model_rows(input int req, output logic [RW-1:0] r0,
                                       output logic [RW-1:0] r1);
        int s;
        s  = 1;
        r0 = '0;
        r1 = '0;
        while (s < req && s < NB) s = s * 2;
        for (int k = 0; k < 2 * NB; k++) begin
            int g;
            int r;
            logic [DW-1:0] word;
            g    = k / (2 * s);
            r    = k % (2 * s);
            word = (r < s) ? top_w[g*s + r] : bot_w[g*s + r - s];
            if (k < NB) r0[k*DW +: DW] = word;
            else        r1[(k-NB)*DW +: DW] = word;
        end
    endfunction

    task automatic set_plan_data();
        for (int j = 0; j < NB; j++) begin
            top_w[j] = 32'h1000_0000 + DW'(j);
            bot_w[j] = 32'h2000_0000 + DW'(j);
        end
    endtask

    // One clock: drive at negedge, check outputs against the model, then advance the model.
    task automatic step(input logic v, input logic d, input logic [SW-1:0] s, input logic r,
                        input logic rnd);
        logic          ev;
        logic          er;
        beat_t         h;
        beat_t         b;
        logic [RW-1:0] r0;
        logic [RW-1:0] r1;
        @(negedge clk);
        if (rnd) begin
            for (int j = 0; j < NB; j++) begin
                top_w[j] = $urandom;
                bot_w[j] = $urandom;
            end
        end
        for (int j = 0; j < NB; j++) begin
            bf_top[j*DW +: DW]    = top_w[j];
            bf_bottom[j*DW +: DW] = bot_w[j];
        end
        in_valid  = v;
        dual_row  = d;
        stride    = s;
        out_ready = r;
        #1;
        ev = (exp_q.size() != 0);
        er = (exp_q.size() == 0) || (exp_q.size() == 1 && r);
        chk1("o_valid", out_valid, ev);
        chk1("o_ready", in_ready, er);
        if (ev) begin
            h = exp_q[0];
            chkw("o_data0", data0, h.d0);
            chkw("o_data1", data1, h.d1);
            chk1("o_row_idx", row_idx, h.idx);
            chk1("o_last", last, h.last);
            if (r) void'(exp_q.pop_front());
        end
        if (v && er) begin
            model_rows(int'(s), r0, r1);
            if (d) begin
                b.d0 = r0; b.d1 = r1; b.idx = 1'b0; b.last = 1'b1;
                exp_q.push_back(b);
            end else begin
                b.d0 = r0; b.d1 = '0; b.idx = 1'b0; b.last = 1'b0;
                exp_q.push_back(b);
                b.d0 = r1; b.d1 = '0; b.idx = 1'b1; b.last = 1'b1;
                exp_q.push_back(b);
            end
        end
    endtask

    initial begin
        logic [RW-1:0] plan_r0;
        logic [RW-1:0] plan_r1;
        total     = 0;
        bad       = 0;
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        dual_row  = 1'b0;
        stride    = '0;
        out_ready = 1'b0;
        bf_top    = '0;
        bf_bottom = '0;
        set_plan_data();
        #2 rst_n = 1'b0;
        @(negedge clk);
        #1;
        chk1("rst_valid", out_valid, 1'b0);
        chk1("rst_ready", in_ready, 1'b1);
        chk1("rst_last", last, 1'b0);
        chk1("rst_row_idx", row_idx, 1'b0);
        chkw("rst_data0", data0, '0);
        chkw("rst_data1", data1, '0);
        @(negedge clk);
        rst_n = 1'b1;

        // Stride 1 dual, anchored to literal expected rows
        plan_r0 = {32'h2000_0001, 32'h1000_0001, 32'h2000_0000, 32'h1000_0000};
        plan_r1 = {32'h2000_0003, 32'h1000_0003, 32'h2000_0002, 32'h1000_0002};
        step(1'b1, 1'b1, 10'd1, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        chkw("plan_s1_row0", data0, plan_r0);
        chkw("plan_s1_row1", data1, plan_r1);
        chk1("plan_s1_last", last, 1'b1);

        // Strides 2, 0, 3, 4, 1023 back-to-back in dual mode
        step(1'b1, 1'b1, 10'd2, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        chkw("plan_s2_row0", data0, {32'h2000_0001, 32'h2000_0000, 32'h1000_0001, 32'h1000_0000});
        step(1'b1, 1'b1, 10'd0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 10'd3, 1'b1, 1'b0);
        step(1'b1, 1'b1, 10'd4, 1'b1, 1'b0);
        step(1'b1, 1'b1, 10'd1023, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        chkw("plan_s1023_row0", data0, {32'h1000_0003, 32'h1000_0002, 32'h1000_0001, 32'h1000_0000});
        chkw("plan_s1023_row1", data1, {32'h2000_0003, 32'h2000_0002, 32'h2000_0001, 32'h2000_0000});
        step(1'b0, 1'b1, 10'd0, 1'b1, 1'b0);

        // Serial stride 2 with a 3-cycle stall; new inputs during the stall must be ignored
        step(1'b1, 1'b0, 10'd2, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 10'd4, 1'b0, 1'b1);
        set_plan_data();
        step(1'b0, 1'b0, 10'd0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 10'd0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 10'd0, 1'b1, 1'b0);

        // Eight back-to-back dual transactions
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, SW'($urandom_range(0, 9)), 1'b1, 1'b1);
        step(1'b0, 1'b1, 10'd0, 1'b1, 1'b0);

        // Random traffic
        for (int i = 0; i < 80; i++) begin
            logic [SW-1:0] rs;
            rs = ($urandom_range(0, 7) == 0) ? SW'($urandom) : SW'($urandom_range(0, 5));
            step(1'($urandom), 1'($urandom), rs, 1'($urandom_range(0, 3) != 0), 1'b1);
        end
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 10'd0, 1'b1, 1'b0);

        // Reset during serial BEAT1 discards the remaining beat
        set_plan_data();
        step(1'b1, 1'b0, 10'd2, 1'b1, 1'b0);
        step(1'b0, 1'b0, 10'd0, 1'b1, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        chk1("rstmid_valid", out_valid, 1'b0);
        chk1("rstmid_last", last, 1'b0);
        chk1("rstmid_row_idx", row_idx, 1'b0);
        chkw("rstmid_data0", data0, '0);
        chkw("rstmid_data1", data1, '0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 10'd0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 10'd4, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 10'd0, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/butterfly_xbar_out_pipe.md
Name: butterfly_xbar_out_pipe

Overview:
- Parametrised, registered successor to the butterfly output crossbar.
- Gathers the top/bottom results of NUM_BF radix-2 butterflies and permutes them into two memory write-back rows according to the current FFT stride.
- Holds the result in an output register with valid/ready handshakes on both sides.
- Optionally serialises the two rows over consecutive beats for a single-port SRAM write path.
- Sits between the butterfly array and the data-memory write port.

Parameters:
- NUM_BF, 4, number of butterflies; power of two, 2..16.
- DATA_W, 32, width of one complex sample word.
- STRIDE_W, 10, width of i_STRIDE.

Ports:
- i_CLK  in  1  clock; all state updates on its rising edge.
- i_RST_N  in  1  asynchronous, active-low reset.
- i_STRIDE  in  STRIDE_W  FFT stride for this transaction.
- i_DUAL_ROW  in  1  1 = both rows in one beat; 0 = two serial beats.
- i_BF_TOP  in  NUM_BF*DATA_W  top outputs; butterfly j occupies word j (bits j*DATA_W +: DATA_W).
- i_BF_BOTTOM  in  NUM_BF*DATA_W  bottom outputs, same packing as i_BF_TOP.
- i_VALID  in  1  input transaction valid.
- o_READY  out  1  block can accept a transaction this cycle.
- o_DATA0  out  NUM_BF*DATA_W  row 0 (dual mode) or the current row (serial mode).
- o_DATA1  out  NUM_BF*DATA_W  row 1 (dual mode); zero in serial mode.
- o_ROW_IDX  out  1  row carried on o_DATA0 (serial mode); 0 in dual mode.
- o_LAST  out  1  final beat of the transaction.
- o_VALID  out  1  output beat valid.
- i_READY  in  1  downstream accepts the beat.

Behaviour:
- Effective stride S:
  - Smallest power of two that is >= i_STRIDE, clamped to [1, NUM_BF].
  - i_STRIDE = 0 gives S = 1.
  - Example for NUM_BF = 4: 0,1 -> 1; 2 -> 2; 3 and above -> 4.
- Permutation: form a 2*NUM_BF-word sequence Q, with index k in 0..2*NUM_BF-1.
  - g = k / (2S), r = k mod (2S).
  - Q[k] = TOP[g*S + r] when r < S; otherwise Q[k] = BOTTOM[g*S + r - S].
  - Row0 word w = Q[w]; Row1 word w = Q[NUM_BF + w].
- Transfer rules:
  - An input transfer occurs when i_VALID & o_READY.
  - An output beat completes when o_VALID & i_READY.
- Capture: on an input transfer, i_STRIDE, i_DUAL_ROW and the permuted rows are captured together; the mode is fixed per transaction.
- State machine:
  - EMPTY: o_VALID = 0.
  - BEAT0: o_VALID = 1.
    - Dual mode: o_DATA0 = row0, o_DATA1 = row1, o_ROW_IDX = 0, o_LAST = 1.
    - Serial mode: o_DATA0 = row0, o_DATA1 = 0, o_ROW_IDX = 0, o_LAST = 0.
  - BEAT1 (serial only): o_VALID = 1, o_DATA0 = row1, o_DATA1 = 0, o_ROW_IDX = 1, o_LAST = 1.
- Transitions:
  - EMPTY -> BEAT0 on an input transfer.
  - BEAT0 with i_READY:
    - serial mode -> BEAT1;
    - dual mode -> BEAT0 if an input transfer occurs in the same cycle, else EMPTY.
  - BEAT1 with i_READY -> BEAT0 if an input transfer occurs in the same cycle, else EMPTY.
  - Without i_READY, state and all outputs hold stable.
- o_READY = (state == EMPTY) | (o_VALID & o_LAST & i_READY).
  - This combinational path from i_READY supports back-to-back transactions.
  - There is no path from i_VALID to o_READY.
- Latency and throughput:
  - Latency is 1 cycle: an input transfer at edge n presents o_VALID after edge n.
  - Dual mode sustains 1 transaction per cycle.
  - Serial mode sustains 1 transaction per 2 cycles.
- Reset (asynchronous assert, synchronous deassert by the system):
  - State = EMPTY; o_VALID, o_LAST and o_ROW_IDX = 0; data registers = 0.
  - Reset asserted mid-transaction discards the pending beat(s); no partial beat is emitted after reset.
- Input changes while o_READY = 0 are ignored; no state is captured.

Test Plan:
All data scenarios use NUM_BF = 4, DATA_W = 32, TOP[j] = 0x1000_000j, BOTTOM[j] = 0x2000_000j (j = 0..3); words are listed w0..w3.
- Stride 1, dual mode, i_READY = 1 -> one cycle later o_DATA0 = {0x10000000, 0x20000000, 0x10000001, 0x20000001}, o_DATA1 = {0x10000002, 0x20000002, 0x10000003, 0x20000003}, o_LAST = 1.
- Stride 2 and stride 0, dual mode:
  - Stride 2 -> row0 = {T0, T1, B0, B1}, row1 = {T2, T3, B2, B3}.
  - Stride 0 -> identical to the stride 1 result.
- Strides 3, 4 and 1023 -> row0 = {T0..T3}, row1 = {B0..B3}, confirming the clamp.
- Serial mode, stride 2, i_READY held low for 3 cycles then high:
  - o_VALID stays 1 with o_DATA0 = row0 stable and o_READY = 0.
  - Then beat ROW_IDX = 0 (o_LAST = 0), then beat ROW_IDX = 1 (o_LAST = 1) carrying {T2, T3, B2, B3}.
- Back-to-back dual transactions with i_VALID = i_READY = 1 for 8 cycles -> 8 consecutive output beats with no bubbles and o_READY = 1 throughout.
- Assert i_RST_N = 0 during serial BEAT1 -> o_VALID = 0 immediately (asynchronous), all outputs 0, no further beats; the next transaction after reset behaves normally.
